// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback stage: micro-op codes, flag bit
// positions, condition codes and the held-entry record.
package alu_pkg;

    typedef enum logic [4:0] {
        UOP_NOP = 5'd0,
        UOP_ADD = 5'd1,
        UOP_SUB = 5'd2,
        UOP_AND = 5'd3,
        UOP_XOR = 5'd4,
        UOP_CMP = 5'd5,
        UOP_LSL = 5'd6,
        UOP_LSR = 5'd7,
        UOP_MOV = 5'd8
    } uop_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } wb_state_e;

    // uop is kept as a raw 5-bit field because codes above MOV can arrive
    typedef struct packed {
        logic [4:0]  uop;
        logic [31:0] result;
        logic [3:0]  flags;
        logic [3:0]  rd;
        logic [3:0]  cond;
        logic        setflags;
    } wb_entry_t;

    function automatic logic is_write_uop(input logic [4:0] uop);
        logic w;
        w = 1'b0;
        case (uop)
            UOP_ADD, UOP_SUB, UOP_AND, UOP_XOR,
            UOP_LSL, UOP_LSR, UOP_MOV: w = 1'b1;
            default:                   w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational ARM condition-code evaluator: pass = cond holds for flags.
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    always_comb begin
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        n    = flags[FLAG_N];
        v    = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// Single-entry ALU writeback stage: conditional register-file write, CPSR
// flag update and bypass, with the condition checked at commit time.
module alu_writeback
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_uop,
    input  logic [31:0] in_result,
    input  logic [3:0]  in_flags,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_cond,
    input  logic        in_setflags,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        rf_ack,
    output logic [3:0]  cpsr_flags,
    output logic        retire,
    output logic        fwd_valid,
    output logic [3:0]  fwd_rd,
    output logic [31:0] fwd_data
);

    wb_state_e state_reg, state_next;
    wb_entry_t entry_reg, entry_next;
    logic [3:0] cpsr_reg, cpsr_next;

    logic held;
    logic cond_pass;
    logic writes;
    logic retire_int;
    logic ready_int;
    logic capture;
    logic flag_load;

    // Evaluated against the live CPSR so an older entry's flags are seen
    alu_cond_eval u_cond_eval (
        .cond  (entry_reg.cond),
        .flags (cpsr_reg),
        .pass  (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            cpsr_reg  <= 4'b0000;
        end else begin
            state_reg <= state_next;
            cpsr_reg  <= cpsr_next;
        end
    end

    // Entry payload only matters while HELD, so it carries no reset
    always_ff @(posedge clk) begin
        entry_reg <= entry_next;
    end

    always_comb begin
        held       = (state_reg == ST_HELD);
        writes     = held & cond_pass & is_write_uop(entry_reg.uop);
        retire_int = held & (!writes | rf_ack);
        ready_int  = !held | retire_int;
        capture    = in_valid & ready_int;
        flag_load  = retire_int & cond_pass
                   & (entry_reg.setflags | (entry_reg.uop == UOP_CMP))
                   & (entry_reg.uop <= UOP_MOV);

        state_next = state_reg;
        entry_next = entry_reg;
        cpsr_next  = cpsr_reg;

        if (state_reg == ST_EMPTY) begin
            if (capture) state_next = ST_HELD;
        end else begin
            if (capture)         state_next = ST_HELD;
            else if (retire_int) state_next = ST_EMPTY;
        end

        if (capture) begin
            entry_next.uop      = in_uop;
            entry_next.result   = in_result;
            entry_next.flags    = in_flags;
            entry_next.rd       = in_rd;
            entry_next.cond     = in_cond;
            entry_next.setflags = in_setflags;
        end

        if (flag_load) cpsr_next = entry_reg.flags;
    end

    assign in_ready   = ready_int;
    assign retire     = retire_int;
    assign rf_we      = writes;
    assign rf_waddr   = entry_reg.rd;
    assign rf_wdata   = entry_reg.result;
    assign fwd_valid  = writes;
    assign fwd_rd     = entry_reg.rd;
    assign fwd_data   = entry_reg.result;
    assign cpsr_flags = cpsr_reg;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_alu_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_uop;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic [3:0]  in_rd;
    logic [3:0]  in_cond;
    logic        in_setflags;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ack;
    logic [3:0]  cpsr_flags;
    logic        retire;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    alu_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_uop      (in_uop),
        .in_result   (in_result),
        .in_flags    (in_flags),
        .in_rd       (in_rd),
        .in_cond     (in_cond),
        .in_setflags (in_setflags),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_ack      (rf_ack),
        .cpsr_flags  (cpsr_flags),
        .retire      (retire),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Conditions come in complementary pairs: cond[3:1] picks the test,
    // cond[0] inverts it (AL/NV included).
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v, base;
        z = f[3]; cy = f[2]; n = f[1]; v = f[0];
        base = 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    logic        m_held = 1'b0, n_held = 1'b0;
    logic [4:0]  m_uop = '0, n_uop = '0;
    logic [31:0] m_res = '0, n_res = '0;
    logic [3:0]  m_flg = '0, n_flg = '0;
    logic [3:0]  m_rd = '0, n_rd = '0;
    logic [3:0]  m_cond = '0, n_cond = '0;
    logic        m_s = 1'b0, n_s = 1'b0;
    logic [3:0]  m_cpsr = '0, n_cpsr = '0;

    always @(negedge clk) begin
        logic pass, wr, ret, rdy;
        pass = cond_ok(m_cond, m_cpsr);
        wr   = m_held && pass && (m_uop inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8});
        ret  = m_held && (!wr || rf_ack);
        rdy  = !m_held || ret;
        if (chk_en) begin
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, rdy});
            chk("m_rf_we", {31'd0, rf_we}, {31'd0, wr});
            chk("m_retire", {31'd0, retire}, {31'd0, ret});
            chk("m_fwd_valid", {31'd0, fwd_valid}, {31'd0, wr});
            chk("m_cpsr", {28'd0, cpsr_flags}, {28'd0, m_cpsr});
            if (wr) begin
                chk("m_waddr", {28'd0, rf_waddr}, {28'd0, m_rd});
                chk("m_wdata", rf_wdata, m_res);
                chk("m_fwd_rd", {28'd0, fwd_rd}, {28'd0, m_rd});
                chk("m_fwd_data", fwd_data, m_res);
            end
        end
        n_held = m_held; n_uop = m_uop; n_res = m_res; n_flg = m_flg;
        n_rd = m_rd; n_cond = m_cond; n_s = m_s; n_cpsr = m_cpsr;
        if (rst) begin
            n_held = 1'b0;
            n_cpsr = 4'b0000;
        end else begin
            if (ret && pass && (m_s || m_uop == 5'd5) && m_uop <= 5'd8) n_cpsr = m_flg;
            if (in_valid && rdy) begin
                n_held = 1'b1;
                n_uop = in_uop; n_res = in_result; n_flg = in_flags;
                n_rd = in_rd; n_cond = in_cond; n_s = in_setflags;
            end else if (ret) begin
                n_held = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        m_held <= n_held; m_uop <= n_uop; m_res <= n_res; m_flg <= n_flg;
        m_rd <= n_rd; m_cond <= n_cond; m_s <= n_s; m_cpsr <= n_cpsr;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] u, input logic [31:0] r, input logic [3:0] f,
                       input logic [3:0] d, input logic [3:0] c, input logic s);
        in_valid = 1'b1; in_uop = u; in_result = r; in_flags = f;
        in_rd = d; in_cond = c; in_setflags = s;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_uop = '0; in_result = '0; in_flags = '0;
        in_rd = '0; in_cond = '0; in_setflags = 1'b0; rf_ack = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_cpsr", {28'd0, cpsr_flags}, 32'd0);

        // ADD r3 = 1, always
        tick(); put(5'd1, 32'h1, 4'b0000, 4'd3, 4'hE, 1'b0);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("add_we", {31'd0, rf_we}, 32'd1);
        chk("add_waddr", {28'd0, rf_waddr}, 32'd3);
        chk("add_wdata", rf_wdata, 32'h1);
        chk("add_retire", {31'd0, retire}, 32'd1);
        tick();
        @(negedge clk);
        chk("add_we_off", {31'd0, rf_we}, 32'd0);
        chk("add_cpsr", {28'd0, cpsr_flags}, 32'd0);

        // CMP sets ZC, then MOV EQ writes, MOV NE does not
        tick(); put(5'd5, 32'h0, 4'b1100, 4'd0, 4'hE, 1'b0);
        tick(); put(5'd8, 32'h12345678, 4'b0000, 4'd5, 4'h0, 1'b0);
        @(negedge clk);
        chk("cmp_we", {31'd0, rf_we}, 32'd0);
        chk("cmp_retire", {31'd0, retire}, 32'd1);
        tick(); put(5'd8, 32'h12345678, 4'b0000, 4'd5, 4'h1, 1'b0);
        @(negedge clk);
        chk("cmp_cpsr", {28'd0, cpsr_flags}, 32'hC);
        chk("moveq_we", {31'd0, rf_we}, 32'd1);
        chk("moveq_waddr", {28'd0, rf_waddr}, 32'd5);
        chk("moveq_wdata", rf_wdata, 32'h12345678);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("movne_we", {31'd0, rf_we}, 32'd0);
        chk("movne_retire", {31'd0, retire}, 32'd1);

        // Write back-pressure
        tick(); put(5'd1, 32'hAABBCCDD, 4'b0000, 4'd2, 4'hE, 1'b0); rf_ack = 1'b0;
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_we", {31'd0, rf_we}, 32'd1);
            chk("bp_waddr", {28'd0, rf_waddr}, 32'd2);
            chk("bp_wdata", rf_wdata, 32'hAABBCCDD);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        rf_ack = 1'b1;
        @(negedge clk);
        chk("bp_retire", {31'd0, retire}, 32'd1);
        chk("bp_ready_ack", {31'd0, in_ready}, 32'd1);

        // Back-to-back: clear flags, SUB sets ZC, MOV EQ sees them
        tick(); put(5'd1, 32'h0, 4'b0000, 4'd7, 4'hE, 1'b1);
        tick(); put(5'd2, 32'h0, 4'b1100, 4'd6, 4'hE, 1'b1);
        tick(); put(5'd8, 32'h55, 4'b0000, 4'd9, 4'h0, 1'b0);
        @(negedge clk);
        chk("b2b_cpsr0", {28'd0, cpsr_flags}, 32'd0);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_cpsr", {28'd0, cpsr_flags}, 32'hC);
        chk("b2b_we", {31'd0, rf_we}, 32'd1);
        chk("b2b_waddr", {28'd0, rf_waddr}, 32'd9);

        // Reset while a write is stalled
        tick(); put(5'd1, 32'hDEAD, 4'b0011, 4'd4, 4'hE, 1'b1); rf_ack = 1'b0;
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("rh_we", {31'd0, rf_we}, 32'd1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rh_we_off", {31'd0, rf_we}, 32'd0);
        chk("rh_cpsr", {28'd0, cpsr_flags}, 32'd0);
        chk("rh_ready", {31'd0, in_ready}, 32'd1);
        chk("rh_retire", {31'd0, retire}, 32'd0);
        rf_ack = 1'b1;

        // cond NV never writes nor updates flags
        tick(); put(5'd1, 32'h77, 4'b0011, 4'd1, 4'hF, 1'b1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("nv_we", {31'd0, rf_we}, 32'd0);
        chk("nv_retire", {31'd0, retire}, 32'd1);
        tick();
        @(negedge clk);
        chk("nv_cpsr", {28'd0, cpsr_flags}, 32'd0);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst         = ($urandom_range(0, 199) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            in_uop      = 5'($urandom_range(0, 12));
            in_result   = $urandom;
            in_flags    = 4'($urandom_range(0, 15));
            in_rd       = 4'($urandom_range(0, 15));
            in_cond     = 4'($urandom_range(0, 15));
            in_setflags = 1'($urandom_range(0, 1));
            rf_ack      = ($urandom_range(0, 3) != 0);
        end
        tick(); rst = 1'b0; in_valid = 1'b0; rf_ack = 1'b1;
        tick(); tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
